// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage sequencer that runs data-memory handshakes, stalls upstream
// while an access is in flight and registers the prioritised MEM result.
module mem_access_ctrl #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid_i,
  input  logic          mem_read_i,
  input  logic          mem_write_i,
  input  logic          jback_i,
  input  logic [DW-1:0] aluresult_i,
  input  logic [DW-1:0] link_data_i,
  input  logic [DW-1:0] store_data_i,
  output logic          dm_req_o,
  output logic          dm_we_o,
  output logic [DW-1:0] dm_addr_o,
  output logic [DW-1:0] dm_wdata_o,
  input  logic          dm_ack_i,
  input  logic [DW-1:0] dm_rdata_i,
  output logic          stall_o,
  output logic          res_valid_o,
  output logic [1:0]    res_sel_o,
  output logic [DW-1:0] res_data_o,
  output logic          err_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] addr_q, wdata_q, link_q, res_data_q, res_data_d;
  logic          jback_q, load_q, store_q, ill_q;
  logic          res_valid_q, res_valid_d, err_q, err_d;
  logic [1:0]    res_sel_q, res_sel_d;
  logic          mem_op, accept, ack, tmo, pass;
  assign mem_op = mem_read_i | mem_write_i;
  assign accept = state_q == IDLE && ex_valid_i && mem_op;
  assign pass   = state_q == IDLE && ex_valid_i && !mem_op;
  assign ack    = state_q == ACCESS && dm_ack_i;
  // An ack on the final allowed cycle still completes the access normally.
  assign tmo    = state_q == ACCESS && !dm_ack_i && cnt_q == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = accept ? ACCESS : (ack | tmo) ? RESP : state_q == RESP ? IDLE : state_q;
    cnt_d   = state_q == ACCESS ? cnt_q + CW'(1) : '0;
  end
  always_comb begin
    dm_req_o   = state_q == ACCESS;
    dm_we_o    = dm_req_o & store_q;
    dm_addr_o  = addr_q;
    dm_wdata_o = wdata_q;
    stall_o    = rst_n & (accept | dm_req_o);
  end
  always_comb begin
    res_valid_d = pass | ack | tmo;
    res_sel_d   = !res_valid_d ? 2'b00 : pass ? (jback_i ? 2'b10 : 2'b00) :
                  tmo ? 2'b11 : jback_q ? 2'b10 : load_q ? 2'b01 : 2'b11;
    res_data_d  = !res_valid_d ? '0 : pass ? (jback_i ? link_data_i : aluresult_i) :
                  tmo ? '0 : jback_q ? link_q : load_q ? dm_rdata_i : '0;
    err_d       = tmo | (ack & ill_q);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      link_q      <= '0;
      jback_q     <= 1'b0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      ill_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_sel_q   <= 2'b00;
      res_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_sel_q   <= res_sel_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
      if (accept) begin
        addr_q  <= aluresult_i;
        wdata_q <= store_data_i;
        link_q  <= link_data_i;
        jback_q <= jback_i;
        load_q  <= mem_read_i & ~mem_write_i;
        store_q <= mem_write_i;
        ill_q   <= mem_read_i & mem_write_i;
      end
    end
  assign res_valid_o = res_valid_q;
  assign res_sel_o   = res_sel_q;
  assign res_data_o  = res_data_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: table vectors, randomized transactions against a transaction-level
// model, and hand-written reset / back-to-back / ignored-input sequences.
module tb_mem_access_ctrl;
  localparam int DW = 32;
  localparam int TO = 15;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ex_valid = 0, mem_read = 0, mem_write = 0, jback = 0, dm_ack = 0;
  logic [DW-1:0] aluresult = 0, link_data = 0, store_data = 0, dm_rdata = 0;
  logic dm_req, dm_we, stall, res_valid, err;
  logic [DW-1:0] dm_addr, dm_wdata, res_data;
  logic [1:0] res_sel;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .mem_read_i(mem_read),
    .mem_write_i(mem_write), .jback_i(jback), .aluresult_i(aluresult),
    .link_data_i(link_data), .store_data_i(store_data), .dm_req_o(dm_req),
    .dm_we_o(dm_we), .dm_addr_o(dm_addr), .dm_wdata_o(dm_wdata), .dm_ack_i(dm_ack),
    .dm_rdata_i(dm_rdata), .stall_o(stall), .res_valid_o(res_valid),
    .res_sel_o(res_sel), .res_data_o(res_data), .err_o(err)
  );

  typedef struct {
    logic rd, wr, jb;
    logic [DW-1:0] alu, link, sd, rdata;
    int dly;
    logic [1:0] sel;
    logic [DW-1:0] data;
    logic err;
    int lat;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Transaction-level reference: outcome depends only on op kind and ack delay.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic memop = v.rd | v.wr;
    logic abort = memop && v.dly >= TO;
    r.lat = !memop ? 1 : abort ? TO + 1 : v.dly + 2;
    r.err = abort || (v.rd && v.wr);
    if (abort) begin r.sel = 2'b11; r.data = 0; end
    else if (v.jb) begin r.sel = 2'b10; r.data = v.link; end
    else if (!memop) begin r.sel = 2'b00; r.data = v.alu; end
    else if (v.rd && !v.wr) begin r.sel = 2'b01; r.data = v.rdata; end
    else begin r.sel = 2'b11; r.data = 0; end
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input string nm);
    int lat = 0;
    logic bad = 0;
    @(negedge clk);
    ex_valid = 1; mem_read = v.rd; mem_write = v.wr; jback = v.jb;
    aluresult = v.alu; link_data = v.link; store_data = v.sd;
    #1 check({nm, ".stall_accept"}, stall, v.rd | v.wr);
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      ex_valid = 0; dm_ack = 0;
      aluresult = $urandom; store_data = $urandom;
      if (dm_req) begin
        if (dm_addr !== v.alu || dm_wdata !== v.sd || dm_we !== v.wr || !stall) bad = 1;
        if (c - 1 == v.dly) begin dm_ack = 1; dm_rdata = v.rdata; end
      end
      #1;
      if (res_valid) begin
        lat = c;
        check({nm, ".sel"}, res_sel, v.sel);
        check({nm, ".data"}, res_data, v.data);
        check({nm, ".err"}, err, v.err);
        check({nm, ".stall_resp"}, stall, 0);
      end
    end
    dm_ack = 0;
    check({nm, ".latency"}, lat, v.lat);
    check({nm, ".dm_if"}, bad, 0);
  endtask

  vec_t tbl[8];
  vec_t rv;
  logic bad;

  initial begin
    tbl[0] = '{0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0, 0, 2'b00, 32'h10, 0, 1};
    tbl[1] = '{0, 0, 1, 32'h5, 32'h400008, 32'h0, 32'h0, 0, 2'b10, 32'h400008, 0, 1};
    tbl[2] = '{1, 0, 0, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 2, 2'b01, 32'hDEADBEEF, 0, 4};
    tbl[3] = '{0, 1, 0, 32'h20, 32'h0, 32'hA5A5A5A5, 32'h0, 0, 2'b11, 32'h0, 0, 2};
    tbl[4] = '{1, 0, 0, 32'h104, 32'h0, 32'h0, 32'h0, 99, 2'b11, 32'h0, 1, 16};
    tbl[5] = '{1, 1, 0, 32'h30, 32'h0, 32'h77, 32'h0, 1, 2'b11, 32'h0, 1, 3};
    tbl[6] = '{1, 0, 1, 32'h40, 32'h44, 32'h0, 32'h1234, 0, 2'b10, 32'h44, 0, 2};
    tbl[7] = '{1, 0, 0, 32'h50, 32'h0, 32'h0, 32'hCAFE, 14, 2'b01, 32'hCAFE, 0, 16};
    #12;
    check("reset.dm_req", dm_req, 0);
    check("reset.stall", stall, 0);
    check("reset.res_valid", res_valid, 0);
    check("reset.res_data", res_data, 0);
    check("reset.err", err, 0);
    rst_n = 1;
    foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 40; i++) begin
      rv.rd = 1'($urandom); rv.wr = 1'($urandom); rv.jb = 1'($urandom_range(0, 3) == 0);
      rv.alu = $urandom; rv.link = $urandom; rv.sd = $urandom; rv.rdata = $urandom;
      rv.dly = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
      run_txn(model(rv), $sformatf("rnd%0d", i));
    end
    // back-to-back non-memory instructions: one result per cycle
    @(negedge clk);
    ex_valid = 1; mem_read = 0; mem_write = 0; jback = 0; aluresult = 32'h11;
    @(negedge clk);
    check("b2b.first", res_data, 32'h11);
    jback = 1; link_data = 32'h22;
    @(negedge clk);
    check("b2b.second_sel", res_sel, 2'b10);
    check("b2b.second_data", res_data, 32'h22);
    ex_valid = 0; jback = 0;
    @(negedge clk);
    check("b2b.idle", res_valid, 0);
    // stray ack and ex_valid=0 in IDLE produce nothing
    dm_ack = 1;
    @(negedge clk);
    dm_ack = 0;
    check("stray_ack.res_valid", res_valid, 0);
    check("stray_ack.dm_req", dm_req, 0);
    // ex_valid during ACCESS is ignored: exactly one result
    @(negedge clk);
    ex_valid = 1; mem_read = 1; aluresult = 32'h200;
    @(negedge clk);
    mem_read = 0; aluresult = 32'h999;
    @(negedge clk);
    dm_ack = 1; dm_rdata = 32'h55;
    @(negedge clk);
    dm_ack = 0; ex_valid = 0;
    check("ignore_ex.data", res_data, 32'h55);
    @(negedge clk);
    check("ignore_ex.no_extra", res_valid, 0);
    // reset asserted mid-ACCESS
    @(negedge clk);
    ex_valid = 1; mem_read = 1; aluresult = 32'h300;
    @(negedge clk);
    ex_valid = 0; mem_read = 0;
    @(negedge clk);
    check("rst_mid.req_before", dm_req, 1);
    rst_n = 0;
    #1;
    check("rst_mid.dm_req", dm_req, 0);
    check("rst_mid.stall", stall, 0);
    check("rst_mid.res_valid", res_valid, 0);
    @(negedge clk);
    rst_n = 1;
    bad = 0;
    dm_ack = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (res_valid || dm_req) bad = 1;
    end
    dm_ack = 0;
    check("rst_mid.no_result", bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
